// File: rtl/alu_serial_sequencer.sv
// Purpose: bit-serial ALU that evaluates one WIDTH-bit op LSB-first, one bit per clock.
// Latency: start accepted at edge 0, done pulses in the cycle after edge WIDTH (WIDTH+1 cycles start-to-done).
// Backpressure: none queued; start is ignored while busy, accepted in IDLE or in the DONE cycle.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start, a, b, op   request and operands; a/b/op latched on the accepted start
//   busy, done        busy while bits are shifting; done is a one-cycle completion pulse
//   result, cout      last completed result and final carry, held until the next done
//   zero, neg, ovf    flags of the held result; ovf only for add/subtract
module alu_serial_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic             accept;
    logic             last_bit;

    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [2:0]       op_q;
    logic             c;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] build;

    logic             b_eff;
    logic             f_bit;
    logic             c_nxt;
    logic [WIDTH-1:0] build_nxt;

    // ---------------------------------------------------------------
    // FSM: state register plus registered busy/done decoded from the
    // next state, so both outputs come straight from flops.
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == SHIFT);
            done  <= (state_nxt == DONE);
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last_bit  = (state == SHIFT) && (cnt == LAST);
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // back-to-back: a start seen in the done cycle is taken here
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // One-bit slice. For arithmetic, op[0] both inverts B and seeds the
    // carry, giving A + ~B + 1 for subtract. For logic ops the carry
    // flop just keeps holding op[0], which doubles as the invert flag
    // and ends up as cout.
    // ---------------------------------------------------------------
    always_comb begin
        b_eff = sh_b[0] ^ op_q[0];
        f_bit = 1'b0;
        c_nxt = c;
        unique case (op_q[2:1])
            2'b00: begin
                f_bit = sh_a[0] ^ b_eff ^ c;
                c_nxt = (sh_a[0] & b_eff) | (sh_a[0] & c) | (b_eff & c);
            end
            2'b01:   f_bit = sh_a[0] | b_eff;
            2'b10:   f_bit = sh_a[0] & b_eff;
            default: f_bit = op_q[0] ? ~sh_b[0] : ~sh_a[0];
        endcase
        build_nxt = {f_bit, build[WIDTH-1:1]};
    end

    // ---------------------------------------------------------------
    // Datapath. Outputs are written on the edge that processes the last
    // bit, i.e. on entry to DONE; at that edge c still holds the carry
    // into the MSB and c_nxt is the carry out of it.
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_a   <= '0;
            sh_b   <= '0;
            op_q   <= '0;
            c      <= 1'b0;
            cnt    <= '0;
            build  <= '0;
            result <= '0;
            cout   <= 1'b0;
            zero   <= 1'b1;
            neg    <= 1'b0;
            ovf    <= 1'b0;
        end else if (accept) begin
            sh_a  <= a;
            sh_b  <= b;
            op_q  <= op;
            c     <= op[0];
            cnt   <= '0;
            build <= '0;
        end else if (state == SHIFT) begin
            sh_a  <= sh_a >> 1;
            sh_b  <= sh_b >> 1;
            c     <= c_nxt;
            build <= build_nxt;
            cnt   <= cnt + 1'b1;
            if (last_bit) begin
                result <= build_nxt;
                cout   <= c_nxt;
                zero   <= (build_nxt == '0);
                neg    <= build_nxt[WIDTH-1];
                ovf    <= (op_q[2:1] == 2'b00) & (c ^ c_nxt);
            end
        end
    end

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// Purpose: self-checking bench for alu_serial_sequencer against an arithmetic reference model.
// Latency: expects done 9 cycles after the start cycle and busy for 8 cycles (WIDTH=8).
// Backpressure: exercises ignored mid-op starts, back-to-back starts and reset aborts.
module tb_alu_serial_sequencer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   op;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         zero;
    logic         neg;
    logic         ovf;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] prev_res;

    alu_serial_sequencer #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .op     (op),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .zero   (zero),
        .neg    (neg),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: whole-word arithmetic straight from the function table.
    function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2:0] o,
                                  output logic [W-1:0] r, output logic c, output logic v);
        logic [W:0] s;
        s = '0;
        r = '0;
        c = o[0];
        v = 1'b0;
        case (o)
            3'd0: begin
                s = {1'b0, x} + {1'b0, y};
                r = s[W-1:0];
                c = s[W];
                v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
            end
            3'd1: begin
                r = x - y;
                c = (x >= y);
                v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
            end
            3'd2: r = x | y;
            3'd3: r = x | ~y;
            3'd4: r = x & y;
            3'd5: r = x & ~y;
            3'd6: r = ~x;
            default: r = ~y;
        endcase
    endfunction

    // Called at a negedge. Starts an op (after 'gap' idle cycles), optionally
    // holds start high throughout (hold) or pulses start mid-op (abuse), then
    // checks latency, busy length and all outputs. Returns at the negedge of
    // the done cycle with start still high if hold was set.
    task automatic exec(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic [2:0] top,
                        input int gap, input bit hold, input bit abuse);
        logic [W-1:0] er;
        logic         ec;
        logic         eo;
        int           busy_cnt;
        int           lat;
        bit           seen;
        model(ta, tbv, top, er, ec, eo);
        if (gap > 0) begin
            start = 1'b0;
            repeat (gap) @(negedge clk);
        end
        a = ta; b = tbv; op = top; start = 1'b1;
        busy_cnt = 0; lat = 0; seen = 1'b0;
        for (int cyc = 1; cyc <= 20 && !seen; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                if (!hold) start = 1'b0;
                a = W'($urandom); b = W'($urandom); op = 3'($urandom);
            end
            if (abuse && !hold) begin
                if (cyc == 3 || cyc == 5) begin
                    start = 1'b1;
                    a = W'($urandom); b = W'($urandom); op = 3'($urandom);
                end
                if (cyc == 4 || cyc == 6) start = 1'b0;
            end
            if (busy) busy_cnt++;
            if (done) begin
                seen = 1'b1;
                lat  = cyc;
            end else begin
                check("result_held", result, prev_res);
            end
        end
        check("done_seen", seen, 1);
        check("latency", lat, 9);
        check("busy_cycles", busy_cnt, 8);
        check("busy_at_done", busy, 0);
        check("result", result, er);
        check("cout", cout, ec);
        check("zero", zero, (er == '0));
        check("neg", neg, er[W-1]);
        check("ovf", ovf, eo);
        prev_res = er;
    endtask

    initial begin
        int ndone;
        rst = 1'b1; start = 1'b1; a = 8'h12; b = 8'h34; op = 3'd0;
        prev_res = '0;

        // reset held 2 cycles with start high, then 3 idle cycles
        repeat (2) @(negedge clk);
        check("busy_in_reset", busy, 0);
        rst = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_zero", zero, 1);
        check("rst_cout", cout, 0);
        check("rst_neg", neg, 0);
        check("rst_ovf", ovf, 0);

        // add overflow
        exec(8'h7F, 8'h01, 3'd0, 0, 1'b0, 1'b0);
        // subtract, then back-to-back with start held
        exec(8'h05, 8'h05, 3'd1, 1, 1'b1, 1'b0);
        exec(8'h03, 8'h05, 3'd1, 0, 1'b1, 1'b0);
        exec(8'h80, 8'h01, 3'd1, 0, 1'b0, 1'b0);
        // logic ops
        exec(8'h0F, 8'hF0, 3'd2, 2, 1'b0, 1'b0);
        exec(8'h0F, 8'hF0, 3'd3, 1, 1'b0, 1'b0);
        exec(8'h0F, 8'hF0, 3'd4, 1, 1'b0, 1'b0);
        exec(8'hFF, 8'h0F, 3'd5, 1, 1'b0, 1'b0);
        exec(8'h55, 8'hF0, 3'd6, 1, 1'b0, 1'b0);
        exec(8'h0F, 8'h00, 3'd7, 1, 1'b0, 1'b0);

        // handshake abuse: extra start pulses and operand churn mid-op
        exec(8'hA5, 8'h3C, 3'd0, 1, 1'b0, 1'b1);
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abuse_single_done", ndone, 0);

        // reset mid-operation at bit 4
        a = 8'h7F; b = 8'h01; op = 3'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_result", result, 0);
        check("abort_zero", zero, 1);
        prev_res = '0;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 0);
        exec(8'h10, 8'h20, 3'd0, 0, 1'b0, 1'b0);

        // randomized ops with random gaps, holds and abuse
        for (int n = 0; n < 40; n++) begin
            bit h;
            h = 1'($urandom);
            exec(W'($urandom), W'($urandom), 3'($urandom), int'($urandom_range(0, 2)), h,
                 h ? 1'b0 : 1'($urandom));
        end
        start = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_serial_sequencer.md
# alu_serial_sequencer

Bit-serial ALU engine that evaluates one WIDTH-bit operation over WIDTH clock cycles. It processes one bit per cycle, LSB first, and holds the carry/invert bit in a flip-flop between bits. It uses the team's 3-bit ALU function encoding {ctrl[1:0], cin} and drives it from the control side. It sits beside the datapath as a low-area, multi-cycle alternative to the ripple ALU and is started by the control unit with a start/busy/done handshake.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- a  input  WIDTH  operand A; latched on the accepted start
- b  input  WIDTH  operand B; latched on the accepted start
- op  input  3  {ctrl[1:0], cin}; latched on the accepted start
- busy  output  1  high while bits are being processed
- done  output  1  one-cycle pulse; result and flags are valid and updated
- result  output  WIDTH  last completed result; held until the next done
- cout  output  1  final carry register value
- zero  output  1  result == 0
- neg  output  1  result[WIDTH-1]
- ovf  output  1  signed overflow; arithmetic ops only, 0 otherwise

## Operation
- Function table (op = ctrl,cin):
  - 000 A+B
  - 001 A−B
  - 010 A|B
  - 011 A|~B
  - 100 A&B
  - 101 A&~B
  - 110 ~A
  - 111 ~B
- States: IDLE, SHIFT, DONE.
- IDLE: busy=0, done=0. start=1 → latch a, b, op into shift registers. Load carry c ← op[0]. Clear bit counter. Go to SHIFT.
- SHIFT: busy=1. Each cycle, take bit i = LSB of the A and B shift registers and compute f_i:
  - ctrl=00: b' = b_i ^ op[0]. f_i = a_i ^ b' ^ c. c ← maj(a_i, b', c).
  - ctrl≠00: logic function per the table. c unchanged, so the invert flag propagates.
  - f_i shifts into the MSB of a build register. A and B shift right. Counter increments.
  - After bit WIDTH−1, go to DONE.
- DONE, held one cycle:
  - done=1, busy=0.
  - result ← build register.
  - cout ← c.
  - zero and neg are derived from the new result.
  - ovf ← (ctrl==00) & (carry into MSB ^ carry out of MSB).
  - Next state is IDLE, or SHIFT if start=1 (back-to-back accepted).
- Subtraction carry is the no-borrow flag: cout=1 iff A ≥ B unsigned.
- Logic ops: cout = op[0].
- start while busy=1 is ignored; it is not queued.
- Operand inputs may change freely after the accepted start cycle.
- result, cout, zero, neg and ovf change only on entry to DONE.
- Arithmetic is modulo 2^WIDTH. No sign extension occurs.

## Timing
- Reset (rst=1 at a rising edge):
  - State goes to IDLE.
  - busy=0, done=0, result=0, cout=0, zero=1, neg=0, ovf=0.
  - Internal shift registers and counter are cleared.
- rst has priority over every other input. A reset during SHIFT or DONE aborts the operation: no done pulse, and result is cleared.
- Latency: start is sampled at edge 0. Bit i is processed at edge i+1. done is high for the single cycle after edge WIDTH.
- From the start-high cycle to the done-high cycle is WIDTH+1 cycles. Throughput is one op per WIDTH+1 cycles with back-to-back starts.
- busy is high for exactly WIDTH cycles per operation.
- If start=1 in the DONE cycle, it is accepted at that edge. busy rises in the next cycle, and done falls in that same cycle.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan
- Reset/idle: assert rst for 2 cycles, then idle 3 cycles → busy=0, done=0, result=0x00, zero=1. start=1 with rst=1 → no busy.
- Add overflow (WIDTH=8): a=0x7F, b=0x01, op=000 → done exactly 9 cycles after the start cycle. result=0x80, cout=0, ovf=1, neg=1, zero=0. busy high for exactly 8 cycles.
- Subtract:
  - a=0x05, b=0x05, op=001 → result=0x00, zero=1, cout=1, ovf=0.
  - Then back-to-back (start held through done): a=0x03, b=0x05 → result=0xFE, cout=0, neg=1.
  - Then a=0x80, b=0x01 → result=0x7F, ovf=1.
- Logic ops, a=0x0F, b=0xF0 unless noted:
  - op=010 → 0xFF.
  - op=011 → 0x0F.
  - op=100 → 0x00, zero=1.
  - op=101 with a=0xFF, b=0x0F → 0xF0.
  - op=110 with a=0x55 → 0xAA.
  - op=111 with b=0x00 → 0xFF, cout=1.
  - ovf=0 for all of these.
- Handshake abuse:
  - Pulse start again at cycles 3 and 5 of a busy op, and change a/b/op mid-op → exactly one done. Result matches the operands latched at the accepted start.
- Reset mid-operation:
  - Start 0x7F+0x01, assert rst for 1 cycle at bit 4 → no done. result=0x00, busy=0 the cycle after reset.
  - Then a fresh op 0x10+0x20 → result=0x30 after 9 cycles.
